// File: rtl/fault_campaign_ctrl.sv
// ---------------------------------------------------------------------------
// fault_campaign_ctrl
//
// Purpose: sequential stuck-at fault campaign for a W-bit adder. Runs one
// fault-free golden pass over every {Cin, Y, X} vector, then for each enabled
// polarity (SA0, SA1) injects a fault at each gate GID_BASE..GID_BASE+NUM_GATES-1
// in turn and replays every vector, counting mismatches against an internal
// golden sum.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   start             begin a campaign (accepted in IDLE or DONE)
//   abort             return to IDLE on the next edge, counters retained
//   pol_sel[1:0]      bit0 enables the SA0 pass, bit1 the SA1 pass
//   dut_S, dut_Cout   adder response
//   X, Y, Cin         stimulus, held stable through APPLY and CHECK
//   fault_en_bus      one-hot fault enable (or zero), fault_val = stuck value
//   busy, done        campaign running / finished (done is a level)
//   golden_fail       mismatch seen with no fault injected
//   err_count         saturating count of mismatching vectors in fault passes
//   detected_mask     bit g set if the fault at gate GID_BASE+g was detected
//   dbg_state         current FSM state (0 IDLE, 1 APPLY, 2 CHECK, 3 DONE)
// ---------------------------------------------------------------------------
module fault_campaign_ctrl #(
    parameter int NG        = 128,
    parameter int W         = 4,
    parameter int NUM_GATES = 8,
    parameter int GID_BASE  = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [1:0]           pol_sel,
    input  logic [W-1:0]         dut_S,
    input  logic                 dut_Cout,
    output logic [W-1:0]         X,
    output logic [W-1:0]         Y,
    output logic                 Cin,
    output logic [NG-1:0]        fault_en_bus,
    output logic                 fault_val,
    output logic                 busy,
    output logic                 done,
    output logic                 golden_fail,
    output logic [15:0]          err_count,
    output logic [NUM_GATES-1:0] detected_mask,
    output logic [1:0]           dbg_state
);

    localparam int VW = 2 * W + 1;
    localparam int GW = (NUM_GATES > 1) ? $clog2(NUM_GATES) : 1;
    localparam logic [VW-1:0] V_LAST = '1;
    localparam logic [GW-1:0] G_LAST = GW'(NUM_GATES - 1);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_APPLY = 2'd1, S_CHECK = 2'd2, S_DONE = 2'd3} state_t;
    typedef enum logic [1:0] {P_GOLD = 2'd0, P_SA0 = 2'd1, P_SA1 = 2'd2} pass_t;

    state_t               state_q, state_d;
    pass_t                pass_q, pass_d;
    logic [VW-1:0]        v_q, v_d;
    logic [GW-1:0]        g_q, g_d;
    logic [1:0]           pol_q, pol_d;
    logic [15:0]          err_q, err_d;
    logic [NUM_GATES-1:0] mask_q, mask_d;
    logic                 gfail_q, gfail_d;
    logic                 done_q, done_d;

    logic [W-1:0]         x_q, x_d, y_q, y_d;
    logic                 cin_q, cin_d;
    logic [NG-1:0]        fen_q, fen_d;
    logic                 fval_q, fval_d;
    logic                 busy_q, busy_d;

    logic [W:0]           golden;
    logic                 mismatch;
    logic                 nxt_pass_ok;
    pass_t                nxt_pass;

    // Golden sum is taken from the registered stimulus, which the DUT sees too.
    assign golden   = {1'b0, x_q} + {1'b0, y_q} + {{W{1'b0}}, cin_q};
    assign mismatch = ({dut_Cout, dut_S} != golden);

    // Which fault pass follows the current one, using pol_sel latched at start.
    always_comb begin
        nxt_pass_ok = 1'b0;
        nxt_pass    = P_SA1;
        case (pass_q)
            P_GOLD: begin
                if (pol_q[0]) begin
                    nxt_pass_ok = 1'b1;
                    nxt_pass    = P_SA0;
                end else if (pol_q[1]) begin
                    nxt_pass_ok = 1'b1;
                end
            end
            P_SA0:   nxt_pass_ok = pol_q[1];
            default: nxt_pass_ok = 1'b0;
        endcase
    end

    // Process 1: state register (plus the loop counters and result registers).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pass_q  <= P_GOLD;
            v_q     <= '0;
            g_q     <= '0;
            pol_q   <= '0;
            err_q   <= '0;
            mask_q  <= '0;
            gfail_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pass_q  <= pass_d;
            v_q     <= v_d;
            g_q     <= g_d;
            pol_q   <= pol_d;
            err_q   <= err_d;
            mask_q  <= mask_d;
            gfail_q <= gfail_d;
            done_q  <= done_d;
        end
    end

    // Process 2: next-state and loop-advance logic. abort overrides everything.
    always_comb begin
        state_d = state_q;
        pass_d  = pass_q;
        v_d     = v_q;
        g_d     = g_q;
        pol_d   = pol_q;
        err_d   = err_q;
        mask_d  = mask_q;
        gfail_d = gfail_q;
        done_d  = done_q;
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_d = S_APPLY;
                        pass_d  = P_GOLD;
                        v_d     = '0;
                        g_d     = '0;
                        pol_d   = pol_sel;
                        err_d   = '0;
                        mask_d  = '0;
                        gfail_d = 1'b0;
                        done_d  = 1'b0;
                    end
                end
                S_APPLY: state_d = S_CHECK;
                S_CHECK: begin
                    if (mismatch && pass_q == P_GOLD) begin
                        gfail_d = 1'b1;
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        if (mismatch) begin
                            if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
                            mask_d[g_q] = 1'b1;
                        end
                        state_d = S_APPLY;
                        v_d     = v_q + 1'b1;  // wraps to 0 after V_LAST
                        if (v_q == V_LAST) begin
                            // The golden pass has no gate loop: it ends after one sweep.
                            if (pass_q == P_GOLD || g_q == G_LAST) begin
                                g_d = '0;
                                if (nxt_pass_ok) begin
                                    pass_d = nxt_pass;
                                end else begin
                                    state_d = S_DONE;
                                    done_d  = 1'b1;
                                end
                            end else begin
                                g_d = g_q + 1'b1;
                            end
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Process 3: registered outputs, derived from the upcoming state so the
    // stimulus and fault enable are already valid during the APPLY cycle.
    always_comb begin
        x_d    = '0;
        y_d    = '0;
        cin_d  = 1'b0;
        fen_d  = '0;
        fval_d = 1'b0;
        busy_d = (state_d == S_APPLY) || (state_d == S_CHECK);
        if (busy_d) begin
            x_d   = v_d[W-1:0];
            y_d   = v_d[2*W-1:W];
            cin_d = v_d[2*W];
            if (pass_d != P_GOLD) begin
                fen_d  = {{(NG-1){1'b0}}, 1'b1} << (GID_BASE + int'(g_d));
                fval_d = (pass_d == P_SA1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q    <= '0;
            y_q    <= '0;
            cin_q  <= 1'b0;
            fen_q  <= '0;
            fval_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            x_q    <= x_d;
            y_q    <= y_d;
            cin_q  <= cin_d;
            fen_q  <= fen_d;
            fval_q <= fval_d;
            busy_q <= busy_d;
        end
    end

    assign X             = x_q;
    assign Y             = y_q;
    assign Cin           = cin_q;
    assign fault_en_bus  = fen_q;
    assign fault_val     = fval_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign golden_fail   = gfail_q;
    assign err_count     = err_q;
    assign detected_mask = mask_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_fault_campaign_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fault_campaign_ctrl
//
// Drives fault_campaign_ctrl against a behavioural adder stub with four
// response modes: 0 correct adder ignoring faults, 1 flips S[0] while gate
// GID_BASE+2 is enabled, 2 always returns X+Y+Cin+1, 3 ripple-carry adder
// where gate 2i is the sum output and gate 2i+1 the carry output of FA i.
// ---------------------------------------------------------------------------
module tb_fault_campaign_ctrl;

    localparam int NG        = 128;
    localparam int W         = 4;
    localparam int NUM_GATES = 8;
    localparam int GID_BASE  = 0;

    logic                 clk;
    logic                 rst_n;
    logic                 start;
    logic                 abort;
    logic [1:0]           pol_sel;
    logic [W-1:0]         dut_S;
    logic                 dut_Cout;
    logic [W-1:0]         X;
    logic [W-1:0]         Y;
    logic                 Cin;
    logic [NG-1:0]        fault_en_bus;
    logic                 fault_val;
    logic                 busy;
    logic                 done;
    logic                 golden_fail;
    logic [15:0]          err_count;
    logic [NUM_GATES-1:0] detected_mask;
    logic [1:0]           dbg_state;

    int n_cmp = 0;
    int n_bad = 0;
    int mode  = 0;
    int onehot_viol  = 0;
    int idle_en_viol = 0;

    fault_campaign_ctrl #(
        .NG(NG), .W(W), .NUM_GATES(NUM_GATES), .GID_BASE(GID_BASE)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .pol_sel(pol_sel),
        .dut_S(dut_S), .dut_Cout(dut_Cout), .X(X), .Y(Y), .Cin(Cin),
        .fault_en_bus(fault_en_bus), .fault_val(fault_val), .busy(busy), .done(done),
        .golden_fail(golden_fail), .err_count(err_count), .detected_mask(detected_mask),
        .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- adder stub ----------------
    function automatic logic [W:0] model_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic c, input int gate, input logic val);
        logic         carry;
        logic         sb;
        logic         co;
        logic [W-1:0] s;
        carry = c;
        s     = '0;
        for (int i = 0; i < W; i++) begin
            sb = x[i] ^ y[i] ^ carry;
            co = (x[i] & y[i]) | (carry & (x[i] ^ y[i]));
            if (gate == 2 * i)     sb = val;
            if (gate == 2 * i + 1) co = val;
            s[i]  = sb;
            carry = co;
        end
        return {carry, s};
    endfunction

    int           gate_sel;
    logic [W:0]   exact;
    logic [W:0]   res;

    always_comb begin
        gate_sel = -1;
        for (int i = 0; i < NUM_GATES; i++)
            if (fault_en_bus[GID_BASE + i]) gate_sel = i;
        exact = {1'b0, X} + {1'b0, Y} + {{W{1'b0}}, Cin};
        case (mode)
            1:       res = exact ^ (fault_en_bus[GID_BASE + 2] ? 5'b00001 : 5'b00000);
            2:       res = exact + 5'd1;
            3:       res = model_add(X, Y, Cin, gate_sel, fault_val);
            default: res = exact;
        endcase
    end

    assign dut_S    = res[W-1:0];
    assign dut_Cout = res[W];

    // Fault bus legality, sampled away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (!$onehot0(fault_en_bus)) onehot_viol++;
            if (!busy && fault_en_bus != '0) idle_en_viol++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_start(input logic [1:0] pol);
        @(negedge clk);
        pol_sel = pol;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_done(output int edges, input int limit);
        edges = 0;
        while (!done && edges < limit) begin
            @(posedge clk);
            #1;
            edges++;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; pol_sel = 2'b00;
        #12;
        n_cmp++; if ({X, Y, Cin, fault_val, busy, done, golden_fail} !== '0) begin n_bad++; $display("FAIL reset_outs got=%h exp=0", {X, Y, Cin, fault_val, busy, done, golden_fail}); end
        n_cmp++; if (fault_en_bus !== '0) begin n_bad++; $display("FAIL reset_fen got=%h exp=0", fault_en_bus); end
        n_cmp++; if ({err_count, detected_mask, dbg_state} !== '0) begin n_bad++; $display("FAIL reset_cnt got=%h exp=0", {err_count, detected_mask, dbg_state}); end
        @(negedge clk);
        rst_n = 1'b1;
        step(2);
        n_cmp++; if (dbg_state !== 2'd0 || busy !== 1'b0) begin n_bad++; $display("FAIL reset_idle state=%0d busy=%b exp 0/0", dbg_state, busy); end
    endtask

    task automatic test_clean_full();
        int edges;
        mode = 0;
        do_start(2'b11);
        n_cmp++; if (busy !== 1'b1 || done !== 1'b0 || dbg_state !== 2'd1) begin n_bad++; $display("FAIL clean_start busy=%b done=%b state=%0d exp 1/0/1", busy, done, dbg_state); end
        wait_done(edges, 20000);
        n_cmp++; if (edges !== 17408) begin n_bad++; $display("FAIL clean_latency got=%0d exp=17408", edges); end
        n_cmp++; if (err_count !== 16'd0) begin n_bad++; $display("FAIL clean_err got=%0d exp=0", err_count); end
        n_cmp++; if (detected_mask !== 8'h00) begin n_bad++; $display("FAIL clean_mask got=%h exp=00", detected_mask); end
        n_cmp++; if (golden_fail !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL clean_flags gf=%b busy=%b exp 0/0", golden_fail, busy); end
        n_cmp++; if ({X, Y, Cin, fault_val} !== '0 || fault_en_bus !== '0) begin n_bad++; $display("FAIL clean_done_outs xyc=%h fen=%h exp 0", {X, Y, Cin, fault_val}, fault_en_bus); end
        n_cmp++; if (onehot_viol !== 0 || idle_en_viol !== 0) begin n_bad++; $display("FAIL fen_onehot viol=%0d idle=%0d exp 0/0", onehot_viol, idle_en_viol); end
    endtask

    task automatic test_single_gate();
        int edges;
        mode = 1;
        do_start(2'b01);
        wait_done(edges, 12000);
        n_cmp++; if (edges !== 9216) begin n_bad++; $display("FAIL gate2_latency got=%0d exp=9216", edges); end
        n_cmp++; if (err_count !== 16'd512) begin n_bad++; $display("FAIL gate2_err got=%0d exp=512", err_count); end
        n_cmp++; if (detected_mask !== 8'b0000_0100) begin n_bad++; $display("FAIL gate2_mask got=%b exp=00000100", detected_mask); end
    endtask

    task automatic test_back_to_back();
        int edges;
        mode = 1;
        do_start(2'b10);
        n_cmp++; if (done !== 1'b0 || err_count !== 16'd0 || detected_mask !== 8'h00) begin n_bad++; $display("FAIL b2b_clear done=%b err=%0d mask=%h exp 0/0/00", done, err_count, detected_mask); end
        wait_done(edges, 12000);
        n_cmp++; if (edges !== 9216) begin n_bad++; $display("FAIL b2b_latency got=%0d exp=9216", edges); end
        n_cmp++; if (err_count !== 16'd512 || detected_mask !== 8'h04) begin n_bad++; $display("FAIL b2b_result err=%0d mask=%h exp 512/04", err_count, detected_mask); end
    endtask

    task automatic test_golden_fail();
        int edges;
        mode = 2;
        do_start(2'b11);
        wait_done(edges, 100);
        n_cmp++; if (edges !== 2) begin n_bad++; $display("FAIL gfail_latency got=%0d exp=2", edges); end
        n_cmp++; if (golden_fail !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL gfail_flags gf=%b busy=%b exp 1/0", golden_fail, busy); end
        n_cmp++; if (err_count !== 16'd0) begin n_bad++; $display("FAIL gfail_err got=%0d exp=0", err_count); end
    endtask

    task automatic test_real_rca();
        int edges;
        int exp_err;
        logic [W:0] gsum;
        logic [W:0] fsum;
        logic [8:0] vv;
        exp_err = 0;
        for (int p = 0; p < 2; p++)
            for (int g = 0; g < NUM_GATES; g++)
                for (int v = 0; v < 512; v++) begin
                    vv   = 9'(v);
                    gsum = {1'b0, vv[3:0]} + {1'b0, vv[7:4]} + {4'b0, vv[8]};
                    fsum = model_add(vv[3:0], vv[7:4], vv[8], g, p[0]);
                    if (fsum != gsum) exp_err++;
                end
        mode = 3;
        do_start(2'b11);
        wait_done(edges, 20000);
        n_cmp++; if (edges !== 17408) begin n_bad++; $display("FAIL rca_latency got=%0d exp=17408", edges); end
        n_cmp++; if (golden_fail !== 1'b0) begin n_bad++; $display("FAIL rca_gfail got=%b exp=0", golden_fail); end
        n_cmp++; if (detected_mask !== 8'hFF) begin n_bad++; $display("FAIL rca_mask got=%h exp=FF", detected_mask); end
        n_cmp++; if (int'(err_count) !== exp_err || exp_err == 0 || exp_err > 8192) begin n_bad++; $display("FAIL rca_err got=%0d exp=%0d", err_count, exp_err); end
    endtask

    task automatic test_abort();
        int edges;
        mode = 1;
        do_start(2'b01);
        step(2999);
        // start while busy must be ignored (sampled at edge 3000)
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        step(272);
        // abort sampled at edge 3273: 100 gate-2 vectors checked so far
        @(negedge clk); abort = 1'b1;
        @(posedge clk); #1; abort = 1'b0;
        n_cmp++; if (busy !== 1'b0 || fault_en_bus !== '0 || done !== 1'b0) begin n_bad++; $display("FAIL abort_outs busy=%b fen=%h done=%b exp 0/0/0", busy, fault_en_bus, done); end
        n_cmp++; if (dbg_state !== 2'd0) begin n_bad++; $display("FAIL abort_state got=%0d exp=0", dbg_state); end
        n_cmp++; if (err_count !== 16'd100 || detected_mask !== 8'h04) begin n_bad++; $display("FAIL abort_retain err=%0d mask=%h exp 100/04", err_count, detected_mask); end
        step(5);
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL abort_stay busy=%b done=%b exp 0/0", busy, done); end
        do_start(2'b01);
        n_cmp++; if (err_count !== 16'd0 || detected_mask !== 8'h00 || {X, Y, Cin} !== '0 || busy !== 1'b1) begin n_bad++; $display("FAIL restart err=%0d mask=%h xyc=%h busy=%b exp 0/00/0/1", err_count, detected_mask, {X, Y, Cin}, busy); end
        wait_done(edges, 12000);
        n_cmp++; if (edges !== 9216 || err_count !== 16'd512) begin n_bad++; $display("FAIL restart_run edges=%0d err=%0d exp 9216/512", edges, err_count); end
    endtask

    task automatic test_async_reset();
        mode = 1;
        do_start(2'b01);
        step(3549);  // CHECK of gate 2, vector 238
        n_cmp++; if (dbg_state !== 2'd2 || fault_en_bus !== 128'h4 || fault_val !== 1'b0) begin n_bad++; $display("FAIL midrun_fault state=%0d fen=%h fval=%b exp 2/4/0", dbg_state, fault_en_bus, fault_val); end
        n_cmp++; if (X !== 4'd14 || Y !== 4'd14 || Cin !== 1'b0) begin n_bad++; $display("FAIL midrun_vec X=%0d Y=%0d Cin=%b exp 14/14/0", X, Y, Cin); end
        n_cmp++; if (err_count !== 16'd238) begin n_bad++; $display("FAIL midrun_err got=%0d exp=238", err_count); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if ({X, Y, Cin, fault_val, busy, done, golden_fail, err_count, detected_mask, dbg_state} !== '0 || fault_en_bus !== '0) begin n_bad++; $display("FAIL async_reset outs=%h fen=%h exp 0", {X, Y, Cin, fault_val, busy, done, golden_fail, err_count, detected_mask, dbg_state}, fault_en_bus); end
        @(negedge clk); rst_n = 1'b1;
        step(3);
        n_cmp++; if (dbg_state !== 2'd0 || busy !== 1'b0) begin n_bad++; $display("FAIL async_release state=%0d busy=%b exp 0/0", dbg_state, busy); end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_clean_full();
        test_single_gate();
        test_back_to_back();
        test_golden_fail();
        test_real_rca();
        test_abort();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fault_campaign_ctrl.md
Name: fault_campaign_ctrl

Overview:
- Sequential fault-injection campaign controller; it is the initiator side of the fault bus (fault_en_bus/fault_val) consumed by the gate-level FA/adder blocks.
- Drives exhaustive stimulus (X, Y, Cin) into a W-bit adder DUT and runs a fault-free golden pass first.
- Then injects each stuck-at fault one gate at a time, compares DUT output against an internal golden sum, and reports error counts and per-gate detection.
- Sits in the testbench/campaign top, wired directly to an adder instance sharing the same NG-wide fault bus.

Parameters:
- NG, 128, width of fault_en_bus.
- W, 4, adder operand width.
- NUM_GATES, 8, number of consecutive gate IDs exercised (2 per FA).
- GID_BASE, 0, first gate ID exercised; GID_BASE+NUM_GATES-1 must be < NG.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin campaign; sampled only in IDLE.
- abort  in  1  return to IDLE next edge; done is not set.
- pol_sel  in  2  bit0 enables the stuck-at-0 pass, bit1 enables the stuck-at-1 pass; 00 means golden pass only.
- dut_S  in  W  DUT sum.
- dut_Cout  in  1  DUT carry out.
- X  out  W  stimulus operand.
- Y  out  W  stimulus operand.
- Cin  out  1  stimulus carry-in.
- fault_en_bus  out  NG  one-hot fault enable, or all zero.
- fault_val  out  1  stuck value.
- busy  out  1  campaign running.
- done  out  1  campaign finished; level signal, cleared on next accepted start.
- golden_fail  out  1  mismatch seen with no fault injected.
- err_count  out  16  total mismatching vectors over the fault passes; saturates at 0xFFFF.
- detected_mask  out  NUM_GATES  bit g set if the fault at gate GID_BASE+g was detected in any enabled pass.

Behaviour:
- All outputs are registered.
- Reset value of every output is 0. Reset is asynchronous at any time, including mid-campaign, and returns the FSM to IDLE.
- States: IDLE, APPLY, CHECK, DONE.
- IDLE -> APPLY when start=1.
  - On that edge: clear err_count, detected_mask, golden_fail and done; set busy=1.
  - Select the golden pass, vector index v=0.
- APPLY (1 cycle):
  - Drive {Cin, Y, X} = v, where v has 2W+1 bits and X = v[W-1:0].
  - In the golden pass, fault_en_bus = 0.
  - In a fault pass, fault_en_bus = one-hot at bit GID_BASE+g, and fault_val = the pass polarity.
  - All driven values are held unchanged through the following CHECK cycle.
- CHECK (1 cycle):
  - Compare {dut_Cout, dut_S} with golden X+Y+Cin, computed in W+1 bits.
  - On a mismatch in the golden pass: set golden_fail and go to DONE immediately.
  - On a mismatch in a fault pass: increment err_count (saturating) and set detected_mask[g].
  - Then advance v.
    - When v wraps past 2^(2W+1)-1: v=0 and advance g.
    - When g wraps past NUM_GATES-1: g=0 and advance the pass.
  - Pass order is golden, then SA0 (if pol_sel[0]), then SA1 (if pol_sel[1]).
  - The golden pass always runs exactly once and has no gate loop.
  - After the last CHECK go to DONE; otherwise go to APPLY.
- DONE:
  - busy=0, done=1; fault_en_bus=0, fault_val=0, X=Y=Cin=0.
  - start=1 begins a new campaign exactly as from IDLE.
- Latency:
  - K = (1 + P*NUM_GATES) * 2^(2W+1), where P = popcount(pol_sel).
  - done is visible after the 2K-th rising edge following the start edge.
  - With defaults and pol_sel=11: K=8704, so 17408 edges.
- start while busy is ignored.
- abort has priority over every transition: next state IDLE, busy=0, fault_en_bus=0, counters retain their values.
- fault_en_bus never has more than one bit set. It is zero in IDLE, DONE and the golden pass.

Test Plan:
- Fault-ignoring DUT stub (correct adder, no fault response), pol_sel=11 -> done after 17408 edges; err_count=0, detected_mask=0, golden_fail=0; fault_en_bus is always one-hot or zero.
- Stub flips S[0] when fault_en_bus[GID_BASE+2]=1, pol_sel=01 -> err_count=512, detected_mask=8'b0000_0100, done after 9216 edges.
- Stub outputs X+Y+Cin+1 always -> golden_fail=1 and done after 2 edges (first vector 0+0+0 mismatches); err_count=0.
- Real RCA with fault injection, pol_sel=11 -> golden_fail=0, detected_mask=8'hFF, err_count>0 and <=8192.
- Assert abort at edge 100 -> busy=0 and fault_en_bus=0 on the next edge, done=0. A new start then restarts from v=0 with counters cleared.
- Drop rst_n asynchronously mid-CHECK -> all outputs are 0 immediately; the FSM is in IDLE after release.
